alu_req_arbiter: RTL and testbench

- Shares one ALU instance between NUM_REQ command requesters.
- Round-robin arbitration: latches the winner's command and drives the ALU input ports for the whole operation. Waits the command-dependent ALU latency, captures RES and flags, and returns them with the requester ID over a valid/ready response port.
- Sits between the command sources and the ALU; replaces direct testbench or driver control of the ALU input pins.

---
 rtl/alu_arb_pkg.sv | 25 ++
 rtl/alu_req_arbiter_pick.sv | 31 +++
 rtl/alu_req_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU request arbiter.
// ALU_ARB_PRIO0_EN (optional) gives requester 0 fixed priority.
package alu_arb_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_CMD_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic [3:0] MUL_CMD_0 = 4'd9;
  localparam logic [3:0] MUL_CMD_1 = 4'd10;

  function automatic logic is_mul(
    input logic       mode,
    input logic [3:0] cmd
  );
    return mode && (cmd == MUL_CMD_0 || cmd == MUL_CMD_1);
  endfunction

endpackage

// File: rtl/alu_req_arbiter_pick.sv
// Combinational round-robin picker: first set request at or after ptr.
// Produces onehot grant, its index and an any-request flag.
module alu_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between NUM_REQ requesters, round-robin, one op at a time.
// Define ALU_ARB_PRIO0_EN to give requester 0 fixed priority.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = ALU_DATA_W,
  parameter int CMD_WIDTH  = ALU_CMD_W,
  parameter int ALU_LAT    = 1,
  parameter int MUL_LAT    = 2,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_opa,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_opb,
  input  logic [NUM_REQ-1:0]              req_cin,
  input  logic [NUM_REQ-1:0]              req_mode,
  input  logic [NUM_REQ*CMD_WIDTH-1:0]    req_cmd,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ID_W-1:0]                 rsp_id,
  output logic [2*DATA_WIDTH-1:0]         rsp_res,
  output logic                            rsp_err,
  output logic                            rsp_oflow,
  output logic                            rsp_cout,
  output logic                            rsp_g,
  output logic                            rsp_l,
  output logic                            rsp_e,
  output logic                            alu_ce,
  output logic [DATA_WIDTH-1:0]           alu_opa,
  output logic [DATA_WIDTH-1:0]           alu_opb,
  output logic                            alu_cin,
  output logic                            alu_mode,
  output logic [1:0]                      alu_inp_valid,
  output logic [CMD_WIDTH-1:0]            alu_cmd,
  input  logic [2*DATA_WIDTH-1:0]         alu_res,
  input  logic                            alu_err,
  input  logic                            alu_oflow,
  input  logic                            alu_cout,
  input  logic                            alu_g,
  input  logic                            alu_l,
  input  logic                            alu_e,
  output logic                            busy
);

  localparam int LAT_MAX = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
  localparam int LW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  arb_state_t              state;
  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         id_q;
  logic [DATA_WIDTH-1:0]   opa_q;
  logic [DATA_WIDTH-1:0]   opb_q;
  logic                    cin_q;
  logic                    mode_q;
  logic [CMD_WIDTH-1:0]    cmd_q;
  logic [LW-1:0]           lat_cnt;

  logic [NUM_REQ-1:0]      pick_req;
  logic [NUM_REQ-1:0]      pick_gnt;
  logic [ID_W-1:0]         pick_idx;
  logic                    pick_any;
  logic [NUM_REQ-1:0]      win_gnt;
  logic [ID_W-1:0]         win_idx;
  logic                    win_any;
  logic                    mul_hit;
  logic [ID_W-1:0]         nxt_ptr;

  alu_rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .req (pick_req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef ALU_ARB_PRIO0_EN
  always_comb begin
    pick_req    = req_valid;
    pick_req[0] = 1'b0;
    win_gnt     = req_valid[0] ? NUM_REQ'(1) : pick_gnt;
    win_idx     = req_valid[0] ? '0 : pick_idx;
    win_any     = req_valid[0] | pick_any;
  end
`else
  always_comb begin
    pick_req = req_valid;
    win_gnt  = pick_gnt;
    win_idx  = pick_idx;
    win_any  = pick_any;
  end
`endif

  assign req_ready = (reset && state == IDLE) ? win_gnt : '0;

  // Upper command bits beyond the 4-bit multiply codes must be zero
  assign mul_hit = is_mul(mode_q, 4'(cmd_q)) && ((cmd_q >> 4) == '0);

  assign nxt_ptr = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      cin_q     <= 1'b0;
      mode_q    <= 1'b0;
      cmd_q     <= '0;
      lat_cnt   <= '0;
      rsp_res   <= '0;
      rsp_err   <= 1'b0;
      rsp_oflow <= 1'b0;
      rsp_cout  <= 1'b0;
      rsp_g     <= 1'b0;
      rsp_l     <= 1'b0;
      rsp_e     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_any) begin
            id_q   <= win_idx;
            opa_q  <= req_opa[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            opb_q  <= req_opb[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            cin_q  <= req_cin[win_idx];
            mode_q <= req_mode[win_idx];
            cmd_q  <= req_cmd[int'(win_idx)*CMD_WIDTH +: CMD_WIDTH];
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          lat_cnt <= mul_hit ? LW'(MUL_LAT - 1) : LW'(ALU_LAT - 1);
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            rsp_res   <= alu_res;
            rsp_err   <= alu_err;
            rsp_oflow <= alu_oflow;
            rsp_cout  <= alu_cout;
            rsp_g     <= alu_g;
            rsp_l     <= alu_l;
            rsp_e     <= alu_e;
            state     <= RESP;
          end else begin
            lat_cnt <= lat_cnt - LW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
`ifdef ALU_ARB_PRIO0_EN
            if (id_q != '0) rr_ptr <= nxt_ptr;
`else
            rr_ptr <= nxt_ptr;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_ce        = (state == ISSUE) || (state == WAIT);
  assign alu_inp_valid = alu_ce ? 2'b11 : 2'b00;
  assign alu_opa       = opa_q;
  assign alu_opb       = opb_q;
  assign alu_cin       = cin_q;
  assign alu_mode      = mode_q;
  assign alu_cmd       = cmd_q;
  assign rsp_valid     = (state == RESP);
  assign rsp_id        = id_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Randomized bench for alu_req_arbiter with a transaction-level model
// and a latency-aware ALU stub that returns garbage before results are ready.
module tb_alu_req_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int CW  = 4;
  localparam int AL  = 1;
  localparam int ML  = 2;
  localparam int IW  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*DW-1:0] req_opa;
  logic [NR*DW-1:0] req_opb;
  logic [NR-1:0]    req_cin;
  logic [NR-1:0]    req_mode;
  logic [NR*CW-1:0] req_cmd;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IW-1:0]    rsp_id;
  logic [2*DW-1:0]  rsp_res;
  logic             rsp_err, rsp_oflow, rsp_cout, rsp_g, rsp_l, rsp_e;
  logic             alu_ce;
  logic [DW-1:0]    alu_opa, alu_opb;
  logic             alu_cin, alu_mode;
  logic [1:0]       alu_inp_valid;
  logic [CW-1:0]    alu_cmd;
  logic [2*DW-1:0]  alu_res;
  logic             alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e;
  logic             busy;

  logic [DW-1:0] p_opa [NR];
  logic [DW-1:0] p_opb [NR];
  logic          p_cin [NR];
  logic          p_mode[NR];
  logic [CW-1:0] p_cmd [NR];

  always #5 clk = ~clk;

  alu_req_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb),
    .req_cin(req_cin), .req_mode(req_mode), .req_cmd(req_cmd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_err(rsp_err), .rsp_oflow(rsp_oflow),
    .rsp_cout(rsp_cout), .rsp_g(rsp_g), .rsp_l(rsp_l), .rsp_e(rsp_e),
    .alu_ce(alu_ce), .alu_opa(alu_opa), .alu_opb(alu_opb),
    .alu_cin(alu_cin), .alu_mode(alu_mode),
    .alu_inp_valid(alu_inp_valid), .alu_cmd(alu_cmd),
    .alu_res(alu_res), .alu_err(alu_err), .alu_oflow(alu_oflow),
    .alu_cout(alu_cout), .alu_g(alu_g), .alu_l(alu_l), .alu_e(alu_e),
    .busy(busy)
  );

  always_comb begin
    req_opa  = '0;
    req_opb  = '0;
    req_cin  = '0;
    req_mode = '0;
    req_cmd  = '0;
    for (int i = 0; i < NR; i++) begin
      req_opa[i*DW +: DW] = p_opa[i];
      req_opb[i*DW +: DW] = p_opb[i];
      req_cin[i]          = p_cin[i];
      req_mode[i]         = p_mode[i];
      req_cmd[i*CW +: CW] = p_cmd[i];
    end
  end

  // Returns {err,oflow,cout,g,l,e,res}
  function automatic logic [21:0] alu_fn(
    input logic [7:0] a, input logic [7:0] b,
    input logic ci, input logic md, input logic [3:0] c
  );
    logic [15:0] r;
    if (md && c == 4'd0)       r = 16'(a) + 16'(b);
    else if (md && c == 4'd1)  r = 16'(a) + 16'(b) + 16'(ci);
    else if (md && c == 4'd9)  r = 16'(a) * 16'(b);
    else if (md && c == 4'd10) r = 16'(a) * 16'(b) + 16'd1;
    else                       r = {a ^ b, b} ^ {12'h0, c};
    return {c >= 4'd13, r[15], r[8], a > b, a < b, a == b, r};
  endfunction

  function automatic int lat_of(input logic md, input logic [3:0] c);
    return (md && (c == 4'd9 || c == 4'd10)) ? ML : AL;
  endfunction

  int          acnt = 0;
  logic [21:0] a_true, a_out;

  always @(posedge clk) acnt <= alu_ce ? acnt + 1 : 0;

  always_comb begin
    a_true = alu_fn(alu_opa, alu_opb, alu_cin, alu_mode, alu_cmd);
    a_out  = a_true;
    if (acnt < lat_of(alu_mode, alu_cmd))
      a_out = {~a_true[21:16], a_true[15:0] ^ 16'hDEAD};
  end

  assign {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e, alu_res} = a_out;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int         id;
    logic [7:0] opa, opb;
    logic       cin, mode;
    logic [3:0] cmd;
    int         lat;
  } op_t;

  op_t         cur;
  bit          m_busy  = 0;
  bit          rst_seen = 0;
  int          m_ptr   = 0;
  int          m_t     = 0;
  int          hs_cnt  = 0;
  int          hs_q[$];
  logic [15:0] last_res;
  logic [NR-1:0] rdy_s = '0;

  function automatic int pick(input logic [NR-1:0] v, input int ptr);
`ifdef ALU_ARB_PRIO0_EN
    if (v[0]) return 0;
    v[0] = 1'b0;
`endif
    for (int k = 0; k < NR; k++)
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [21:0] e;
    int w;
    rdy_s = reset ? req_ready : '0;
    if (!reset) begin
      if (rst_seen) begin
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_ce", 32'(alu_ce), 0);
        chk("rst_iv", 32'(alu_inp_valid), 0);
        chk("rst_rvalid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
      end
      rst_seen = 1;
      m_busy   = 0;
      m_ptr    = 0;
    end else begin
      rst_seen = 0;
      if (m_busy) begin
        m_t++;
        chk("busy_op", 32'(busy), 1);
        chk("ready_op", 32'(req_ready), 0);
        chk("rsp_valid", 32'(rsp_valid), 32'(m_t >= cur.lat + 2));
        if (m_t <= cur.lat + 1) begin
          chk("alu_iv", 32'(alu_inp_valid), 3);
          chk("alu_ce", 32'(alu_ce), 1);
          chk("alu_ops", {8'h0, alu_opa, alu_opb, 3'h0, alu_cin,
              alu_cmd}, {8'h0, cur.opa, cur.opb, 3'h0, cur.cin, cur.cmd});
          chk("alu_mode", 32'(alu_mode), 32'(cur.mode));
        end else begin
          e = alu_fn(cur.opa, cur.opb, cur.cin, cur.mode, cur.cmd);
          chk("alu_iv_off", 32'(alu_inp_valid), 0);
          chk("rsp_id", 32'(rsp_id), 32'(cur.id));
          chk("rsp_res", 32'(rsp_res), 32'(e[15:0]));
          chk("rsp_flags", 32'({rsp_err, rsp_oflow, rsp_cout, rsp_g,
              rsp_l, rsp_e}), 32'(e[21:16]));
          last_res = rsp_res;
          if (rsp_ready) begin
            hs_q.push_back(cur.id);
            hs_cnt++;
`ifdef ALU_ARB_PRIO0_EN
            if (cur.id != 0) m_ptr = (cur.id + 1) % NR;
`else
            m_ptr = (cur.id + 1) % NR;
`endif
            m_busy = 0;
          end
        end
      end else begin
        w = pick(req_valid, m_ptr);
        chk("busy_idle", 32'(busy), 0);
        chk("rvalid_idle", 32'(rsp_valid), 0);
        chk("req_ready", 32'(req_ready),
            (w < 0) ? 32'h0 : (32'h1 << w));
        if (w >= 0) begin
          cur.id   = w;
          cur.opa  = p_opa[w];
          cur.opb  = p_opb[w];
          cur.cin  = p_cin[w];
          cur.mode = p_mode[w];
          cur.cmd  = p_cmd[w];
          cur.lat  = lat_of(p_mode[w], p_cmd[w]);
          m_busy   = 1;
          m_t      = 0;
        end
      end
    end
  end

  int stim    = 0;
  bit rr_rand = 0;

  task automatic new_payload(input int i);
    logic [3:0] cmds [5];
    cmds[0] = 4'd0; cmds[1] = 4'd1; cmds[2] = 4'd9; cmds[3] = 4'd10;
    cmds[4] = 4'($urandom);
    p_opa[i]  = 8'($urandom);
    p_opb[i]  = 8'($urandom);
    p_cin[i]  = 1'($urandom);
    p_mode[i] = ($urandom % 4) != 0;
    p_cmd[i]  = cmds[$urandom % 5];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (stim == 2) begin
        if (!req_valid[i] || rdy_s[i]) begin
          new_payload(i);
          req_valid[i] = 1'b1;
        end
      end else if (stim == 1) begin
        if (rdy_s[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i]) begin
          if ($urandom % 3 == 0) begin
            new_payload(i);
            req_valid[i] = 1'b1;
          end
        end else if ($urandom % 16 == 0) req_valid[i] = 1'b0;
      end else if (rdy_s[i]) req_valid[i] = 1'b0;
    end
    if (rr_rand) rsp_ready = ($urandom % 4) != 0;
  endtask

  task automatic wait_hs(input int n, input int budget);
    int target;
    target = hs_cnt + n;
    for (int c = 0; c < budget && hs_cnt < target; c++) step();
    chk("hs_timeout", 32'(hs_cnt), 32'(target));
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    for (int c = 0; c < cycles; c++) step();
    reset = 1'b1;
  endtask

  task automatic load(input int i, input logic [7:0] a, input logic [7:0] b,
                      input logic md, input logic [3:0] c);
    p_opa[i] = a; p_opb[i] = b; p_cin[i] = 1'b0;
    p_mode[i] = md; p_cmd[i] = c;
    req_valid[i] = 1'b1;
  endtask

  initial begin
    int cyc;
    reset     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NR; i++) new_payload(i);
    for (int c = 0; c < 3; c++) step();
    req_valid = '0;
    reset     = 1'b1;
    step();

    load(2, 8'h0F, 8'h01, 1'b1, 4'd0);
    wait_hs(1, 40);
    chk("add_id", 32'(hs_q[$]), 2);
    chk("add_res", 32'(last_res), 32'h0010);

    step();
    load(0, 8'd3, 8'd4, 1'b1, 4'd9);
    wait_hs(1, 40);
    chk("mul_res", 32'(last_res), 32'd12);

    do_reset(2);
    hs_q.delete();
    stim = 2;
    wait_hs(8, 200);
    for (int k = 0; k < 8; k++) begin
`ifdef ALU_ARB_PRIO0_EN
      chk("fair_seq", 32'(hs_q[k]), 0);
`else
      chk("fair_seq", 32'(hs_q[k]), 32'(k % NR));
`endif
    end

    stim = 0;
    req_valid = '0;
    wait_hs(0, 1);
    for (int c = 0; c < 20 && m_busy; c++) step();
    rsp_ready = 1'b0;
    load(1, 8'h55, 8'h23, 1'b1, 4'd10);
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      step();
      if (req_valid[1] == 1'b0) req_valid[3] = 1'b1;
      cyc++;
    end
    chk("bp_rvalid", 32'(rsp_valid), 1);
    for (int c = 0; c < 5; c++) step();
    chk("bp_hold_id", 32'(rsp_id), 1);
    rsp_ready = 1'b1;
    wait_hs(2, 60);

    load(1, 8'h11, 8'h22, 1'b1, 4'd9);
    cyc = 0;
    while (!(m_busy && m_t == 2) && cyc < 40) begin
      step();
      cyc++;
    end
    chk("abort_wait", 32'(alu_inp_valid), 3);
    cyc = hs_cnt;
    do_reset(1);
    chk("abort_norsp", 32'(hs_cnt), 32'(cyc));
    hs_q.delete();
    stim = 2;
    wait_hs(1, 40);
    chk("abort_first", 32'(hs_q[0]), 0);

    stim    = 1;
    rr_rand = 1;
    for (int c = 0; c < 600; c++) step();
    stim    = 0;
    rr_rand = 0;
    rsp_ready = 1'b1;
    req_valid = '0;
    for (int c = 0; c < 40 && (m_busy || busy); c++) step();
    chk("drain_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
